// File: rtl/tmr_voter_pkg.sv
// Shared types and the per-channel TMR classification function.
// Purely combinational content; no latency, no flow control.
package tmr_voter_pkg;

    typedef enum logic [1:0] {
        HEALTHY = 2'd0,
        SUSPECT = 2'd1,
        FAULTY  = 2'd2
    } replica_state_e;

    // Channels are zero-extended to VOTE_W so one function serves any W up to this width.
    localparam int VOTE_W   = 64;
    localparam int STREAK_W = 8;

    typedef logic [VOTE_W-1:0] word_t;

    typedef struct packed {
        word_t      voted;
        logic       corrected;
        logic       uncorrectable;
        logic [2:0] attr;
    } vote_t;

    function automatic vote_t classify_channel(
        input word_t      a,
        input word_t      b,
        input word_t      c,
        input logic [2:0] faulty
    );
        vote_t r;
        r = '0;
        if (faulty[0]) begin
            r.voted         = b;
            r.uncorrectable = (b != c);
        end else if (faulty[1]) begin
            r.voted         = a;
            r.uncorrectable = (a != c);
        end else if (faulty[2]) begin
            r.voted         = a;
            r.uncorrectable = (a != b);
        end else begin
            r.voted = (a & b) | (a & c) | (b & c);
            if (a == b && b != c) begin
                r.corrected = 1'b1;
                r.attr      = 3'b100;
            end else if (a == c && a != b) begin
                r.corrected = 1'b1;
                r.attr      = 3'b010;
            end else if (b == c && a != b) begin
                r.corrected = 1'b1;
                r.attr      = 3'b001;
            end else if (a != b && a != c && b != c) begin
                r.uncorrectable = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tmr_voter_if.sv
// Beat bus of the TMR voter: replica inputs and clear in, voted data and fault status out.
// No backpressure; a beat is accepted every cycle valid_i is high.
interface tmr_voter_if #(
    parameter int N_CH  = 4,
    parameter int W     = 32,
    parameter int CNT_W = 8
);
    logic                valid_i;
    logic [N_CH*W-1:0]   in_1_i;
    logic [N_CH*W-1:0]   in_2_i;
    logic [N_CH*W-1:0]   in_3_i;
    logic                clear_i;
    logic                valid_o;
    logic [N_CH*W-1:0]   voted_o;
    logic [N_CH-1:0]     err_corrected_o;
    logic [N_CH-1:0]     err_uncorrectable_o;
    logic [2:0]          replica_fault_o;
    logic [3*CNT_W-1:0]  replica_err_cnt_o;
    logic                degraded_o;

    modport slave (
        input  valid_i, in_1_i, in_2_i, in_3_i, clear_i,
        output valid_o, voted_o, err_corrected_o, err_uncorrectable_o,
               replica_fault_o, replica_err_cnt_o, degraded_o
    );

    modport master (
        output valid_i, in_1_i, in_2_i, in_3_i, clear_i,
        input  valid_o, voted_o, err_corrected_o, err_uncorrectable_o,
               replica_fault_o, replica_err_cnt_o, degraded_o
    );
endinterface

// File: rtl/tmr_replica_monitor.sv
// Health FSM, mismatch streak and saturating error counter for one replica.
// State updates on the clock edge; at_thresh_o is combinational so the top can arbitrate retirement.
module tmr_replica_monitor
    import tmr_voter_pkg::*;
#(
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             mismatch_i,
    input  logic             clear_i,
    input  logic             retire_gnt_i,
    output replica_state_e   state_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_thresh_o
);
    localparam logic [STREAK_W-1:0] LAST = STREAK_W'(THRESH - 1);

    replica_state_e      state_q;
    logic [STREAK_W-1:0] streak_q;
    logic [CNT_W-1:0]    cnt_q;

    assign at_thresh_o = valid_i && mismatch_i && (state_q == SUSPECT) && (streak_q == LAST);
    assign state_o     = state_q;
    assign cnt_o       = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= HEALTHY;
            streak_q <= '0;
            cnt_q    <= '0;
        end else if (valid_i) begin
            if (mismatch_i && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
            case (state_q)
                HEALTHY: begin
                    if (mismatch_i) begin
                        state_q  <= SUSPECT;
                        streak_q <= STREAK_W'(1);
                    end
                end
                SUSPECT: begin
                    if (!mismatch_i) begin
                        state_q  <= HEALTHY;
                        streak_q <= '0;
                    end else if (streak_q != LAST) begin
                        streak_q <= streak_q + 1'b1;
                    end else if (retire_gnt_i) begin
                        state_q  <= FAULTY;
                        streak_q <= '0;
                    end
                    // Denied retirement parks the replica at THRESH-1.
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tmr_voter_monitor.sv
// Registered multi-channel TMR voter with per-replica fault attribution and retirement.
// Latency 1 cycle; no backpressure, one beat per cycle.
module tmr_voter_monitor
    import tmr_voter_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int W      = 32,
    parameter int THRESH = 4,
    parameter int CNT_W  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    tmr_voter_if.slave bus
);
    replica_state_e     state [3];
    logic [CNT_W-1:0]   cnt [3];
    logic [2:0]         faulty;
    logic [2:0]         at_thresh;
    logic [2:0]         grant;
    logic [2:0]         attr_any;
    logic [2:0]         mismatch;
    logic               degraded;
    logic               mon_valid;
    word_t              a_w, b_w, c_w;
    vote_t              v;
    word_t              vote_w [N_CH];
    logic [N_CH*W-1:0]  voted_d, voted_q;
    logic [N_CH-1:0]    corr_d, corr_q;
    logic [N_CH-1:0]    uncorr_d, uncorr_q;
    logic               valid_q;
    logic [3*CNT_W-1:0] cnt_flat;

    always_comb begin
        faulty = '0;
        for (int r = 0; r < 3; r++) faulty[r] = (state[r] == FAULTY);
    end
    assign degraded = |faulty;

    always_comb begin
        a_w      = '0;
        b_w      = '0;
        c_w      = '0;
        v        = '0;
        vote_w   = '{default: '0};
        voted_d  = '0;
        corr_d   = '0;
        uncorr_d = '0;
        attr_any = '0;
        for (int c = 0; c < N_CH; c++) begin
            a_w = '0;
            b_w = '0;
            c_w = '0;
            a_w[W-1:0] = bus.in_1_i[c*W +: W];
            b_w[W-1:0] = bus.in_2_i[c*W +: W];
            c_w[W-1:0] = bus.in_3_i[c*W +: W];
            v = classify_channel(a_w, b_w, c_w, faulty);
            vote_w[c]          = v.voted;
            voted_d[c*W +: W]  = vote_w[c][W-1:0];
            corr_d[c]          = v.corrected;
            uncorr_d[c]        = v.uncorrectable;
            attr_any           = attr_any | v.attr;
        end
    end

    if (W < VOTE_W) begin : g_pad
        logic pad_unused;
        always_comb begin
            pad_unused = 1'b0;
            for (int c = 0; c < N_CH; c++) pad_unused = pad_unused ^ (^vote_w[c][VOTE_W-1:W]);
        end
    end

    // Healthy replicas stay frozen while degraded, so the monitors see no valid beats then.
    assign mon_valid = bus.valid_i & ~degraded;
    assign mismatch  = attr_any & {3{bus.valid_i}};

    always_comb begin
        grant = '0;
        if (at_thresh[0])      grant = 3'b001;
        else if (at_thresh[1]) grant = 3'b010;
        else if (at_thresh[2]) grant = 3'b100;
    end

    for (genvar r = 0; r < 3; r++) begin : g_mon
        tmr_replica_monitor #(
            .THRESH (THRESH),
            .CNT_W  (CNT_W)
        ) u_mon (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .valid_i      (mon_valid),
            .mismatch_i   (mismatch[r]),
            .clear_i      (bus.clear_i),
            .retire_gnt_i (grant[r]),
            .state_o      (state[r]),
            .cnt_o        (cnt[r]),
            .at_thresh_o  (at_thresh[r])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            voted_q  <= '0;
            corr_q   <= '0;
            uncorr_q <= '0;
        end else begin
            valid_q  <= bus.valid_i;
            corr_q   <= bus.valid_i ? corr_d : '0;
            uncorr_q <= bus.valid_i ? uncorr_d : '0;
            if (bus.valid_i) voted_q <= voted_d;
        end
    end

    always_comb begin
        cnt_flat = '0;
        for (int r = 0; r < 3; r++) cnt_flat[r*CNT_W +: CNT_W] = cnt[r];
    end

    assign bus.valid_o             = valid_q;
    assign bus.voted_o             = voted_q;
    assign bus.err_corrected_o     = corr_q;
    assign bus.err_uncorrectable_o = uncorr_q;
    assign bus.replica_fault_o     = faulty;
    assign bus.replica_err_cnt_o   = cnt_flat;
    assign bus.degraded_o          = degraded;

endmodule

// File: tb/tb_tmr_voter_monitor.sv
// Directed and randomized checks of tmr_voter_monitor against a behavioural model;
// two instances share stimulus, one with 8-bit and one with 2-bit error counters.
module tb_tmr_voter_monitor;
    localparam int N_CH   = 4;
    localparam int W      = 32;
    localparam int THRESH = 4;
    localparam int BW     = N_CH * W;
    localparam int M_OK   = 0;
    localparam int M_SUS  = 1;
    localparam int M_BAD  = 2;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    tmr_voter_if #(.N_CH(N_CH), .W(W), .CNT_W(8)) bus8 ();
    tmr_voter_if #(.N_CH(N_CH), .W(W), .CNT_W(2)) bus2 ();

    assign bus2.valid_i = bus8.valid_i;
    assign bus2.in_1_i  = bus8.in_1_i;
    assign bus2.in_2_i  = bus8.in_2_i;
    assign bus2.in_3_i  = bus8.in_3_i;
    assign bus2.clear_i = bus8.clear_i;

    tmr_voter_monitor #(.N_CH(N_CH), .W(W), .THRESH(THRESH), .CNT_W(8)) dut8 (
        .clk_i (clk_i), .rst_i (rst_i), .bus (bus8.slave));
    tmr_voter_monitor #(.N_CH(N_CH), .W(W), .THRESH(THRESH), .CNT_W(2)) dut2 (
        .clk_i (clk_i), .rst_i (rst_i), .bus (bus2.slave));

    // Reference model: replica health, streak and unsaturated mismatch count.
    int st [3];
    int streak [3];
    int cnt [3];
    logic            exp_valid;
    logic [BW-1:0]   exp_voted;
    logic [N_CH-1:0] exp_corr, exp_unc;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [2:0]  ef;
        logic [23:0] ec8;
        logic [5:0]  ec2;
        for (int r = 0; r < 3; r++) begin
            ef[r]          = (st[r] == M_BAD);
            ec8[r*8 +: 8]  = (cnt[r] > 255) ? 8'd255 : 8'(cnt[r]);
            ec2[r*2 +: 2]  = (cnt[r] > 3) ? 2'd3 : 2'(cnt[r]);
        end
        chk("valid_o",       BW'(bus8.valid_o),             BW'(exp_valid));
        chk("voted_o",       bus8.voted_o,                  exp_voted);
        chk("err_corrected", BW'(bus8.err_corrected_o),     BW'(exp_corr));
        chk("err_uncorr",    BW'(bus8.err_uncorrectable_o), BW'(exp_unc));
        chk("fault",         BW'(bus8.replica_fault_o),     BW'(ef));
        chk("degraded",      BW'(bus8.degraded_o),          BW'(|ef));
        chk("cnt8",          BW'(bus8.replica_err_cnt_o),   BW'(ec8));
        chk("cnt2",          BW'(bus2.replica_err_cnt_o),   BW'(ec2));
        chk("voted_o_c2",    bus2.voted_o,                  exp_voted);
        chk("fault_c2",      BW'(bus2.replica_fault_o),     BW'(ef));
    endtask

    task automatic step(input logic v, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic [BW-1:0] c, input logic clr, input logic rst);
        logic [W-1:0] x [3];
        logic [W-1:0] maj;
        logic [2:0]   mm;
        int f, h0, h1, odd, ones;
        bit granted;
        bus8.valid_i = v;
        bus8.in_1_i  = a;
        bus8.in_2_i  = b;
        bus8.in_3_i  = c;
        bus8.clear_i = clr;
        rst_i        = rst;
        f = -1;
        for (int r = 0; r < 3; r++) if (st[r] == M_BAD) f = r;
        mm = '0;
        if (rst) begin
            exp_valid = 1'b0;
            exp_voted = '0;
            exp_corr  = '0;
            exp_unc   = '0;
            for (int r = 0; r < 3; r++) begin st[r] = M_OK; streak[r] = 0; cnt[r] = 0; end
        end else begin
            exp_valid = v;
            exp_corr  = '0;
            exp_unc   = '0;
            if (v) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    x[0] = a[ch*W +: W];
                    x[1] = b[ch*W +: W];
                    x[2] = c[ch*W +: W];
                    if (f >= 0) begin
                        h0 = (f == 0) ? 1 : 0;
                        h1 = (f == 2) ? 1 : 2;
                        exp_voted[ch*W +: W] = x[h0];
                        exp_unc[ch] = (x[h0] != x[h1]);
                    end else if (x[0] == x[1] && x[1] == x[2]) begin
                        exp_voted[ch*W +: W] = x[0];
                    end else begin
                        odd = -1;
                        for (int r = 0; r < 3; r++)
                            if (x[(r+1)%3] == x[(r+2)%3] && x[r] != x[(r+1)%3]) odd = r;
                        if (odd >= 0) begin
                            exp_voted[ch*W +: W] = x[(odd+1)%3];
                            exp_corr[ch] = 1'b1;
                            mm[odd] = 1'b1;
                        end else begin
                            for (int i = 0; i < W; i++) begin
                                ones = 0;
                                for (int r = 0; r < 3; r++) ones += int'(x[r][i]);
                                maj[i] = (ones >= 2);
                            end
                            exp_voted[ch*W +: W] = maj;
                            exp_unc[ch] = 1'b1;
                        end
                    end
                end
            end
            if (clr) begin
                for (int r = 0; r < 3; r++) begin st[r] = M_OK; streak[r] = 0; cnt[r] = 0; end
            end else if (v && f < 0) begin
                granted = 1'b0;
                for (int r = 0; r < 3; r++) begin
                    if (mm[r]) cnt[r]++;
                    if (!mm[r]) begin
                        st[r] = M_OK; streak[r] = 0;
                    end else if (st[r] == M_OK) begin
                        st[r] = M_SUS; streak[r] = 1;
                    end else if (streak[r] + 1 < THRESH) begin
                        streak[r]++;
                    end else if (!granted) begin
                        st[r] = M_BAD; streak[r] = 0; granted = 1'b1;
                    end
                end
            end
        end
        @(posedge clk_i);
        #1;
        check_outputs();
    endtask

    function automatic logic [BW-1:0] fill(input logic [W-1:0] w);
        return {N_CH{w}};
    endfunction

    logic [BW-1:0] A, F, B, C, D, G, P1, P2, P3, Z, Y, base, ra, rb, rc;
    logic [W-1:0]  wd;
    int bad;

    initial begin
        for (int r = 0; r < 3; r++) begin st[r] = M_OK; streak[r] = 0; cnt[r] = 0; end
        exp_valid = 1'b0; exp_voted = '0; exp_corr = '0; exp_unc = '0;

        // Reset and clean beats.
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        A = fill(32'hA5A5A5A5);
        step(1'b1, A, A, A, 1'b0, 1'b0);
        chk("plan_latency1", bus8.voted_o, A);
        repeat (9) step(1'b1, A, A, A, 1'b0, 1'b0);

        // Replica 2 wrong on channel 1 for three beats.
        F = fill(32'hFFFFFFFF);
        B = F; B[1*W +: W] = '0;
        repeat (3) step(1'b1, F, B, F, 1'b0, 1'b0);
        chk("plan_corr_ch1", BW'(bus8.err_corrected_o), BW'(4'b0010));
        step(1'b1, F, F, F, 1'b0, 1'b0);
        chk("plan_cnt_r1", BW'(bus8.replica_err_cnt_o[15:8]), BW'(8'd3));
        chk("plan_nofault", BW'(bus8.replica_fault_o), BW'(3'b000));

        // Replica 3 retired after four consecutive mismatches.
        C = F; C[0 +: W] = 32'h12345678;
        repeat (4) step(1'b1, F, F, C, 1'b0, 1'b0);
        chk("plan_retire", BW'(bus8.replica_fault_o), BW'(3'b100));
        chk("plan_degraded", BW'(bus8.degraded_o), BW'(1'b1));
        G = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, A, A, G, 1'b0, 1'b0);
        chk("plan_deg_vote", bus8.voted_o, A);
        chk("plan_deg_noflag", BW'(bus8.err_uncorrectable_o | bus8.err_corrected_o), '0);
        D = A; D[2*W +: W] = '0;
        step(1'b1, A, D, A, 1'b0, 1'b0);
        chk("plan_deg_unc", BW'(bus8.err_uncorrectable_o), BW'(4'b0100));
        step(1'b0, A, A, A, 1'b1, 1'b0);
        chk("plan_clear_fault", BW'(bus8.replica_fault_o), '0);

        // All three differ on channel 3.
        P1 = A; P1[3*W +: W] = 32'd1;
        P2 = A; P2[3*W +: W] = 32'd2;
        P3 = A; P3[3*W +: W] = 32'd4;
        step(1'b1, P1, P2, P3, 1'b0, 1'b0);
        chk("plan_maj_ch3", BW'(bus8.voted_o[3*W +: W]), '0);
        chk("plan_unc_ch3", BW'(bus8.err_uncorrectable_o), BW'(4'b1000));
        chk("plan_unc_nocnt", BW'(bus8.replica_err_cnt_o), '0);

        // Replica 0 mismatching on alternate beats: saturation without retirement.
        Z = A; Z[0 +: W] = 32'h0F0F0F0F;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, Z, A, A, 1'b0, 1'b0);
            step(1'b1, A, A, A, 1'b0, 1'b0);
        end
        chk("plan_sat2", BW'(bus2.replica_err_cnt_o[1:0]), BW'(2'd3));
        chk("plan_cnt10", BW'(bus8.replica_err_cnt_o[7:0]), BW'(8'd10));
        chk("plan_sat_nofault", BW'(bus2.replica_fault_o), '0);
        step(1'b1, Z, A, A, 1'b1, 1'b0);
        chk("plan_clr_flag", BW'(bus8.err_corrected_o), BW'(4'b0001));
        chk("plan_clr_cnt", BW'(bus2.replica_err_cnt_o), '0);
        step(1'b0, G, A, Z, 1'b0, 1'b0);
        chk("plan_hold", bus8.voted_o, A);

        // Reset in the middle of a streak.
        Y = A; Y[1*W +: W] = 32'hDEADBEEF;
        repeat (3) step(1'b1, A, A, Y, 1'b0, 1'b0);
        step(1'b1, A, A, Y, 1'b0, 1'b1);
        chk("plan_rst_voted", bus8.voted_o, '0);
        repeat (3) step(1'b1, A, A, Y, 1'b0, 1'b0);
        chk("plan_rst_noretire", BW'(bus8.replica_fault_o), '0);
        step(1'b1, A, A, A, 1'b0, 1'b0);

        // Randomized traffic with a rotating preferred-bad replica.
        for (int i = 0; i < 480; i++) begin
            bad = (i / 40) % 3;
            base = {$urandom, $urandom, $urandom, $urandom};
            ra = base; rb = base; rc = base;
            for (int ch = 0; ch < N_CH; ch++) begin
                wd = $urandom | 32'h1;
                if ($urandom_range(0, (bad == 0) ? 1 : 11) == 0) ra[ch*W +: W] ^= wd;
                wd = $urandom | 32'h2;
                if ($urandom_range(0, (bad == 1) ? 1 : 11) == 0) rb[ch*W +: W] ^= wd;
                wd = $urandom | 32'h4;
                if ($urandom_range(0, (bad == 2) ? 1 : 11) == 0) rc[ch*W +: W] ^= wd;
            end
            step($urandom_range(0, 9) != 0, ra, rb, rc,
                 ($urandom_range(0, 59) == 0) || (i % 40 == 0),
                 $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tmr_voter_monitor.md
# tmr_voter_monitor

Registered, multi-channel TMR voter with per-replica fault tracking. It votes N_CH independent W-bit channels from three replicas and attributes each corrected error to the replica that caused it. A replica that disagrees for THRESH consecutive valid cycles is retired, and voting degrades to two-way compare. It sits at replicated-pipeline boundaries in the fault-tolerant cv32e40p, feeding status to the fault-management logic.

## Interface

Parameters:
- N_CH, 4: number of independent channels.
- W, 32: bits per channel.
- THRESH, 4: consecutive attributed mismatches before a replica is retired (2..255).
- CNT_W, 8: width of the per-replica saturating error counters.

Ports:
- One clock; reset is synchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  inputs valid this cycle.
- in_1_i / in_2_i / in_3_i  in  N_CH*W  replica inputs; channel c occupies [c*W +: W].
- clear_i  in  1  clears replica states, streaks and counters.
- valid_o  out  1  voted data valid.
- voted_o  out  N_CH*W  voted data.
- err_corrected_o  out  N_CH  single-replica error masked on the channel.
- err_uncorrectable_o  out  N_CH  no two replicas agree on the channel.
- replica_fault_o  out  3  replica r is retired (FAULTY).
- replica_err_cnt_o  out  3*CNT_W  per-replica attributed-error count; replica r occupies [r*CNT_W +: CNT_W].
- degraded_o  out  1  one replica is retired.

## Operation

- Per-channel classification in normal mode (no replica FAULTY):
  - All three replicas equal: no error.
  - Exactly two replicas equal: output the agreeing value, assert err_corrected_o[c], and attribute a mismatch to the odd replica.
  - All three pairwise different: output the bitwise majority, assert err_uncorrectable_o[c], no attribution.
- A replica is mismatching in a valid cycle if it is attributed on any channel.
- Per-replica FSM:
  - HEALTHY: on mismatch, go to SUSPECT with streak=1.
  - SUSPECT: on mismatch, streak++; when streak reaches THRESH, go to FAULTY. On a valid cycle without mismatch, return to HEALTHY with streak=0.
  - FAULTY: sticky until clear_i or rst_i.
- Non-valid cycles change no state.
- Error counter: +1 per valid cycle in which the replica is mismatching; saturates at 2^CNT_W-1.
- Degraded mode (exactly one replica FAULTY):
  - Output the lower-indexed healthy replica.
  - If the two healthy replicas differ, assert err_uncorrectable_o[c].
  - err_corrected_o is always 0.
  - No attribution, so streaks and counters of the healthy replicas are frozen.
- At most one replica can be FAULTY at a time. If two replicas would reach THRESH in the same cycle, only the lower-indexed one is retired; the other stays SUSPECT with streak=THRESH-1.
- clear_i (with or without valid_i):
  - All FSMs return to HEALTHY; streaks and counters go to 0.
  - The data of that cycle is still voted and output using the pre-clear state.
  - Mismatches in that cycle are not counted.
- rst_i has priority over clear_i.

## Timing

- Reset values: valid_o=0, voted_o=0, err_corrected_o=0, err_uncorrectable_o=0, replica_fault_o=0, replica_err_cnt_o=0, degraded_o=0. All FSMs HEALTHY, streaks 0.
- Latency is 1 cycle: inputs sampled at edge k with valid_i=1 appear at voted_o, valid_o and the error flags after edge k.
- err_* flags are 0 whenever valid_o=0. voted_o holds its last value when valid_o=0.
- Retirement appears on replica_fault_o and degraded_o at the same edge as the output of the THRESH-th mismatching beat. Degraded voting applies from the next valid input onward.
- Counters and flags update at the same edge as the corresponding voted output.
- There is no backpressure; the block accepts a beat every cycle.

## Structure

- tmr_voter_pkg holds:
  - replica_state_e enum {HEALTHY, SUSPECT, FAULTY};
  - a pure function classifying one channel (inputs: three values plus a faulty-mask; outputs: voted value, corrected, uncorrectable, 3-bit attribution).
- Sub-module tmr_replica_monitor: one instance per replica. It contains the FSM, the streak counter and the saturating error counter. Inputs: valid, mismatch, clear, retire-grant. Outputs: state, count, at_thresh.
- The top level owns:
  - the channel classification loop;
  - output registers;
  - retire arbitration, lowest index wins.

## Test plan

- Defaults, all replicas 0xA5A5A5A5 on every channel, 10 valid beats: voted_o=input, all flags 0, counters 0, latency 1.
- in_2 channel 1 = 0x0 (others 0xFFFFFFFF) for 3 beats, then clean: err_corrected_o=4'b0010 for 3 beats; replica_err_cnt[1]=3; replica 1 back to HEALTHY, replica_fault_o=0.
- in_3 wrong on channel 0 for 4 consecutive beats: replica_fault_o=3'b100 and degraded_o=1 with the 4th output. Next beat in_3 garbage: voted_o=in_1, no flags. Then in_1≠in_2 on channel 2: err_uncorrectable_o=4'b0100.
- Channel 3 with in_1=1, in_2=2, in_3=4: voted_o ch3=0, err_uncorrectable_o[3]=1, no counter change.
- CNT_W=2, replica 0 mismatching on alternate valid beats for 10 mismatches: counter saturates at 3, never FAULTY. Then clear_i with valid_i=1 and a mismatch: beat voted and flagged, counter=0.
- rst_i asserted mid-streak (replica 2 streak 3): all outputs 0 next cycle. After release, 3 more mismatches do not retire the replica.
